fanin_arbiter: RTL and testbench
================================

Name: fanin_arbiter

Overview:
Arbitrates shared output link ownership among NUM_PORT fan-in link element controllers.
- Accepts per-port path requests and message-termination flags.
- Issues a registered, exclusive grant to one port at a time, using a round-robin policy.
- On path release, pulses a release flag to every non-owner port so waiting ports re-check their IDs.
- Drives the mux select for the shared forward/back token path.
- Sits between the fan-in link controllers and the link output mux inside each link element.

Parameters:
NUM_PORT, 4, number of requesting fan-in ports (2..8)
WIDTH_SEL, $clog2(NUM_PORT), width of the owner index
MAX_HOLD, 0, grant watchdog in cycles; 0 disables the watchdog
WIDTH_HOLD, 16, width of the hold counter (MAX_HOLD < 2**WIDTH_HOLD)

Ports:
clock  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
I_Req  in  NUM_PORT  per-port path request (level, held until granted or dropped)
I_Trm  in  NUM_PORT  per-port termination: owner has sent its release token
I_Nack  in  1  back-pressure from downstream link; freezes the watchdog counter
O_Grt  out  NUM_PORT  one-hot grant, registered
O_Rls  out  NUM_PORT  one-cycle release pulse to non-owner ports
O_Sel  out  WIDTH_SEL  owner index for the output mux
O_Busy  out  1  path currently owned
O_TimeOut  out  1  one-cycle pulse: watchdog forced a release

Behaviour:
- Reset values: O_Grt=0, O_Rls=0, O_Sel=0, O_Busy=0, O_TimeOut=0, FSM=IDLE, RR pointer=0, hold counter=0.
- All outputs are registered.
- FSM states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any I_Req is set, select the first requester at or after the RR pointer, wrapping modulo NUM_PORT.
  - Next cycle: O_Grt[k]=1, O_Sel=k, O_Busy=1, FSM→GRANT. Latency is request to grant = 1 cycle.
  - With no request, stay in IDLE.
- GRANT:
  - O_Grt[k] is held while I_Trm[k]=0 and I_Req[k]=1.
  - I_Trm[k]=1, or I_Req[k] dropping, causes FSM→RELEASE on the next cycle.
  - I_Trm and I_Req of non-owner ports are ignored in this state.
- Watchdog: in GRANT the hold counter increments every cycle with I_Nack=0 and saturates at all-ones. If MAX_HOLD≠0 and the counter reaches MAX_HOLD:
  - O_TimeOut is pulsed for 1 cycle.
  - FSM→RELEASE, exactly as if I_Trm[k] had been asserted.
- RELEASE (exactly 1 cycle):
  - O_Grt=0, O_Busy=0.
  - O_Rls[i]=1 for all i≠k, whether or not they are requesting.
  - RR pointer ← (k+1) mod NUM_PORT; hold counter cleared; FSM→IDLE.
  - The next grant appears no earlier than 1 cycle after RELEASE (minimum 2 idle cycles between owners). This lets released ports update their match state.
- O_Sel keeps the last owner in IDLE and RELEASE, and only changes together with a new grant.
- Simultaneous I_Trm[k] and watchdog expiry: treated as a normal release; O_TimeOut=0.
- Single requester: the same port may be re-granted after IDLE; the RR pointer still advances.
- Reset asserted mid-grant: all outputs clear on the next edge, no O_Rls pulse, and the pointer returns to 0.

Decomposition:
- Shared link package: add the enum fsm_link_arb {aRB_IDLE, aRB_GRANT, aRB_RELEASE} and the constant DEFAULT_MAX_HOLD.
- One sub-module, rr_pick: a combinational round-robin priority picker.
  - Inputs: request vector and pointer.
  - Outputs: found flag and index.
  - It is reusable by the fan-out side.
- The counter and FSM stay in fanin_arbiter.

Test Plan:
- Reset then I_Req=4'b0100 → O_Grt=4'b0100 and O_Sel=2 one cycle later; O_Busy=1.
- I_Req=4'b1111 held; each owner asserts I_Trm 3 cycles after its grant → grant order 0,1,2,3,0. Each release shows O_Rls equal to the complement of the owner bit for 1 cycle.
- Owner 1 granted, port 3 raises I_Req and I_Trm[3] → no effect on the grant; O_Sel stays 1.
- MAX_HOLD=8, owner never terminates, I_Nack=1 for 4 of the cycles → O_TimeOut pulses at cycle 12 after the grant, then RELEASE.
- I_Trm[k] on the same cycle as watchdog expiry → release occurs with O_TimeOut=0.
- Reset asserted while port 2 is granted → next cycle all outputs 0; then I_Req=4'b1100 → grant goes to port 2 (pointer reset to 0 scans 0,1,2).

Source files
------------

// File: rtl/fanin_arbiter_pkg.sv
// Shared link-element definitions: arbiter FSM encoding and watchdog default.
package fanin_arbiter_pkg;

    typedef enum logic [1:0] {
        aRB_IDLE    = 2'd0,
        aRB_GRANT   = 2'd1,
        aRB_RELEASE = 2'd2
    } fsm_link_arb;

    // Watchdog disabled unless a link element overrides it.
    localparam int unsigned DEFAULT_MAX_HOLD = 0;

endpackage

// File: rtl/fanin_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int unsigned NUM_PORT  = 4,
    parameter int unsigned WIDTH_SEL = $clog2(NUM_PORT)
) (
    input  logic [NUM_PORT-1:0]  req,
    input  logic [WIDTH_SEL-1:0] ptr,
    output logic                 found_c,
    output logic [WIDTH_SEL-1:0] idx_c
);

    always_comb begin
        int unsigned pos;
        pos     = 0;
        found_c = 1'b0;
        idx_c   = '0;
        for (int unsigned i = 0; i < NUM_PORT; i++) begin
            pos = (32'(ptr) + i) % NUM_PORT;
            if (!found_c && req[WIDTH_SEL'(pos)]) begin
                found_c = 1'b1;
                idx_c   = WIDTH_SEL'(pos);
            end
        end
    end

endmodule

// File: rtl/fanin_arbiter.sv
// Round-robin owner arbiter for the shared output link of a link element,
// with release broadcast to waiting ports and an optional grant watchdog.
module fanin_arbiter
    import fanin_arbiter_pkg::*;
#(
    parameter int unsigned NUM_PORT   = 4,
    parameter int unsigned WIDTH_SEL  = $clog2(NUM_PORT),
    parameter int unsigned MAX_HOLD   = DEFAULT_MAX_HOLD,
    parameter int unsigned WIDTH_HOLD = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_PORT-1:0]  I_Req,
    input  logic [NUM_PORT-1:0]  I_Trm,
    input  logic                 I_Nack,
    output logic [NUM_PORT-1:0]  O_Grt,
    output logic [NUM_PORT-1:0]  O_Rls,
    output logic [WIDTH_SEL-1:0] O_Sel,
    output logic                 O_Busy,
    output logic                 O_TimeOut
);

    // Expiry is flagged on the edge where the counter steps onto MAX_HOLD.
    localparam bit                    WDOG_ON   = (MAX_HOLD != 0);
    localparam logic [WIDTH_HOLD-1:0] HOLD_LAST = WIDTH_HOLD'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [WIDTH_SEL-1:0]  LAST_PORT = WIDTH_SEL'(NUM_PORT - 1);

    fsm_link_arb           state_q, state_d;
    logic [WIDTH_SEL-1:0]  ptr_q, ptr_d;
    logic [WIDTH_HOLD-1:0] hold_q, hold_d;
    logic [NUM_PORT-1:0]   grt_d, rls_d;
    logic [WIDTH_SEL-1:0]  sel_d;
    logic                  busy_d, tout_d;

    logic                  pick_found_c;
    logic [WIDTH_SEL-1:0]  pick_idx_c;
    logic                  owner_done_c;
    logic                  expire_c;
    logic [WIDTH_HOLD-1:0] hold_inc_c;

    rr_pick #(
        .NUM_PORT  (NUM_PORT),
        .WIDTH_SEL (WIDTH_SEL)
    ) u_pick (
        .req     (I_Req),
        .ptr     (ptr_q),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    // Only the owner's lines matter while granted; O_Sel holds the owner index.
    assign owner_done_c = I_Trm[O_Sel] | ~I_Req[O_Sel];
    assign expire_c     = WDOG_ON && !I_Nack && (hold_q == HOLD_LAST);
    assign hold_inc_c   = (&hold_q) ? hold_q : hold_q + WIDTH_HOLD'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grt_d   = O_Grt;
        rls_d   = '0;
        sel_d   = O_Sel;
        busy_d  = O_Busy;
        tout_d  = 1'b0;
        case (state_q)
            aRB_IDLE: begin
                if (pick_found_c) begin
                    state_d = aRB_GRANT;
                    grt_d   = NUM_PORT'(1) << pick_idx_c;
                    sel_d   = pick_idx_c;
                    busy_d  = 1'b1;
                end
            end
            aRB_GRANT: begin
                if (!I_Nack) begin
                    hold_d = hold_inc_c;
                end
                if (owner_done_c || expire_c) begin
                    state_d = aRB_RELEASE;
                    grt_d   = '0;
                    busy_d  = 1'b0;
                    rls_d   = ~(NUM_PORT'(1) << O_Sel);
                    tout_d  = expire_c & ~owner_done_c;
                end
            end
            aRB_RELEASE: begin
                // Extra idle cycle lets released ports refresh their match state.
                state_d = aRB_IDLE;
                hold_d  = '0;
                ptr_d   = (O_Sel == LAST_PORT) ? '0 : O_Sel + WIDTH_SEL'(1);
            end
            default: begin
                state_d = aRB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= aRB_IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            O_Grt     <= '0;
            O_Rls     <= '0;
            O_Sel     <= '0;
            O_Busy    <= 1'b0;
            O_TimeOut <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            O_Grt     <= grt_d;
            O_Rls     <= rls_d;
            O_Sel     <= sel_d;
            O_Busy    <= busy_d;
            O_TimeOut <= tout_d;
        end
    end

endmodule

// File: tb/tb_fanin_arbiter.sv
// Bench for fanin_arbiter: directed vector table, grant rotation sequence,
// and randomized traffic checked against a transaction-level owner model.
module tb_fanin_arbiter;

    localparam int NP = 4;
    localparam int MH = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] I_Req, I_Trm;
    logic       I_Nack;
    logic [3:0] O_Grt, O_Rls;
    logic [1:0] O_Sel;
    logic       O_Busy, O_TimeOut;

    fanin_arbiter #(
        .NUM_PORT   (NP),
        .WIDTH_SEL  (2),
        .MAX_HOLD   (MH),
        .WIDTH_HOLD (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .I_Req     (I_Req),
        .I_Trm     (I_Trm),
        .I_Nack    (I_Nack),
        .O_Grt     (O_Grt),
        .O_Rls     (O_Rls),
        .O_Sel     (O_Sel),
        .O_Busy    (O_Busy),
        .O_TimeOut (O_TimeOut)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] trm;
        logic       nack;
        logic [3:0] grt;
        logic [3:0] rls;
        logic [1:0] sel;
        logic       busy;
        logic       tout;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: who owns the link, who owned it last, where the scan starts.
    int         m_owner, m_last, m_ptr, m_hold;
    bit         m_rel;
    logic [3:0] e_rls;
    logic       e_tout;

    task automatic add(input logic rst, input logic [3:0] req, input logic [3:0] trm,
                       input logic nack, input logic [3:0] grt, input logic [3:0] rls,
                       input logic [1:0] sel, input logic busy, input logic tout);
        vec_t v;
        v.rst = rst; v.req = req; v.trm = trm; v.nack = nack;
        v.grt = grt; v.rls = rls; v.sel = sel; v.busy = busy; v.tout = tout;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [3:0] req, input logic [3:0] trm,
                         input logic nack);
        reset  = rst;
        I_Req  = req;
        I_Trm  = trm;
        I_Nack = nack;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] grt, input logic [3:0] rls,
                         input logic [1:0] sel, input logic busy, input logic tout);
        n_vec++;
        if (O_Grt !== grt || O_Rls !== rls || O_Sel !== sel ||
            O_Busy !== busy || O_TimeOut !== tout) begin
            n_bad++;
            $display("FAIL %s @%0t: got grt=%b rls=%b sel=%0d busy=%b tout=%b, want grt=%b rls=%b sel=%0d busy=%b tout=%b",
                     name, $time, O_Grt, O_Rls, O_Sel, O_Busy, O_TimeOut,
                     grt, rls, sel, busy, tout);
        end
    endtask

    task automatic model_step(input logic rst, input logic [3:0] req, input logic [3:0] trm,
                              input logic nack);
        e_rls  = 4'b0;
        e_tout = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_rel = 0;
        end else if (m_rel) begin
            m_rel  = 0;
            m_ptr  = (m_last + 1) % NP;
            m_hold = 0;
        end else if (m_owner >= 0) begin
            bit done, wd;
            if (!nack) m_hold++;
            done = trm[2'(m_owner)] || !req[2'(m_owner)];
            wd   = !nack && (m_hold == MH);
            if (done || wd) begin
                e_rls   = 4'hF & ~(4'(1) << m_owner);
                e_tout  = wd && !done;
                m_owner = -1;
                m_rel   = 1;
            end
        end else begin
            for (int i = 0; i < NP; i++) begin
                int j;
                j = (m_ptr + i) % NP;
                if (req[2'(j)]) begin
                    m_owner = j;
                    m_last  = j;
                    break;
                end
            end
        end
    endtask

    initial begin
        logic [3:0] rq, tm;
        logic       rs, nk;
        int         k;

        // Directed table: single grant, foreign-port noise, drop release, re-grant.
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);
        add(0, 4'b0100, 4'b0100, 0, 4'b0000, 4'b1011, 2, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0, 0);
        add(0, 4'b0010, 4'b0000, 0, 4'b0010, 4'b0000, 1, 1, 0);
        add(0, 4'b1010, 4'b1000, 0, 4'b0010, 4'b0000, 1, 1, 0);
        add(0, 4'b1010, 4'b1000, 1, 4'b0010, 4'b0000, 1, 1, 0);
        add(0, 4'b1000, 4'b0000, 0, 4'b0000, 4'b1101, 1, 0, 0);
        add(0, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 1, 0, 0);
        add(0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 3, 1, 0);
        add(0, 4'b1000, 4'b0000, 1, 4'b1000, 4'b0000, 3, 1, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0111, 3, 0, 0);
        add(0, 4'b1000, 4'b0000, 0, 4'b0000, 4'b0000, 3, 0, 0);
        add(0, 4'b1000, 4'b0000, 0, 4'b1000, 4'b0000, 3, 1, 0);
        add(0, 4'b1000, 4'b1000, 0, 4'b0000, 4'b0111, 3, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 3, 0, 0);
        // Watchdog: 12 held cycles, 4 with back-pressure, expiry on the 12th.
        add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0, 1, 0);
        for (int s = 1; s <= 12; s++) begin
            nk = (s == 3 || s == 5 || s == 7 || s == 9);
            if (s < 12) add(0, 4'b0001, 4'b0000, nk, 4'b0001, 4'b0000, 0, 1, 0);
            else        add(0, 4'b0001, 4'b0000, nk, 4'b0000, 4'b1110, 0, 0, 1);
        end
        add(0, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // Termination on the same edge the watchdog would expire.
        add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0, 1, 0);
        for (int s = 1; s <= 7; s++)
            add(0, 4'b0001, 4'b0000, 0, 4'b0001, 4'b0000, 0, 1, 0);
        add(0, 4'b0001, 4'b0001, 0, 4'b0000, 4'b1110, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        // Reset mid-grant with pointer parked at 3.
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);
        add(0, 4'b0100, 4'b0100, 0, 4'b0000, 4'b1011, 2, 0, 0);
        add(0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 2, 0, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);
        add(1, 4'b0100, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0);
        add(0, 4'b1100, 4'b0000, 0, 4'b0100, 4'b0000, 2, 1, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].req, tbl[i].trm, tbl[i].nack);
            check($sformatf("vec%0d", i), tbl[i].grt, tbl[i].rls, tbl[i].sel,
                  tbl[i].busy, tbl[i].tout);
        end

        // All ports requesting: grants rotate 0,1,2,3,0.
        drive(1, 4'b0000, 4'b0000, 0);
        check("rot_reset", 4'b0000, 4'b0000, 0, 0, 0);
        for (int g = 0; g < 5; g++) begin
            k = g % NP;
            drive(0, 4'b1111, 4'b0000, 0);
            check($sformatf("rot_grant%0d", g), 4'(1) << k, 4'b0000, 2'(k), 1, 0);
            for (int h = 0; h < 3; h++) begin
                drive(0, 4'b1111, 4'b0000, 0);
                check($sformatf("rot_hold%0d", g), 4'(1) << k, 4'b0000, 2'(k), 1, 0);
            end
            drive(0, 4'b1111, 4'(1) << k, 0);
            check($sformatf("rot_rls%0d", g), 4'b0000, 4'hF & ~(4'(1) << k), 2'(k), 0, 0);
            drive(0, 4'b1111, 4'b0000, 0);
            check($sformatf("rot_idle%0d", g), 4'b0000, 4'b0000, 2'(k), 0, 0);
        end

        // Randomized traffic against the model.
        model_step(1, 4'b0000, 4'b0000, 0);
        drive(1, 4'b0000, 4'b0000, 0);
        rq = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            rs = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 3) == 0) rq[i] = ~rq[i];
                tm[i] = ($urandom_range(0, 5) == 0);
            end
            nk = ($urandom_range(0, 3) == 0);
            model_step(rs, rq, tm, nk);
            drive(rs, rq, tm, nk);
            check($sformatf("rand%0d", c),
                  (m_owner >= 0) ? (4'(1) << m_owner) : 4'b0000,
                  e_rls, 2'(m_last), (m_owner >= 0), e_tout);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
